// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush and a writeback forwarding tap.
// Optional performance counters are compiled in when MEM_WB_PERF_EN is defined.
module mem_wb_skid_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WB_W      = 2,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned REGWR_BIT = 1,
  parameter int unsigned M2R_BIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [RA_W-1:0]   rd_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [RA_W-1:0]   rd_out,
  output logic [DATA_W-1:0] addr_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic              fwd_en,
  output logic [RA_W-1:0]   fwd_rd,
`ifdef MEM_WB_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [DATA_W-1:0] fwd_data
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  entry_t h_q, h_d;
  entry_t s_q, s_d;
  logic   in_ready_q, in_ready_d;

  entry_t in_beat;
  logic   accept;
  logic   pop;

  always_comb begin
    in_beat.wb    = wb_in;
    in_beat.rd    = rd_in;
    in_beat.addr  = addr_in;
    in_beat.rdata = rdata_in;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    if (flush) begin
      // Entry contents are left as-is; only occupancy matters once emptied.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            h_d     = in_beat;
          end
        end
        StOne: begin
          if (accept && !pop) begin
            state_d = StFull;
            s_d     = in_beat;
          end else if (accept && pop) begin
            h_d     = in_beat;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d = StOne;
            h_d     = s_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      h_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      h_q        <= h_d;
      s_q        <= s_d;
    end
  end

  assign wb_out    = h_q.wb;
  assign rd_out    = h_q.rd;
  assign addr_out  = h_q.addr;
  assign rdata_out = h_q.rdata;
  assign wdata_out = h_q.wb[M2R_BIT] ? h_q.rdata : h_q.addr;
  // x0 is hardwired to zero, so it is never a forwarding source.
  assign fwd_en    = out_valid & h_q.wb[REGWR_BIT] & (h_q.rd != '0);
  assign fwd_rd    = h_q.rd;
  assign fwd_data  = wdata_out;

`ifdef MEM_WB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (out_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (!out_valid) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (flush) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_mem_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, fwd_en;
  logic [1:0]  wb_in, wb_out;
  logic [4:0]  rd_in, rd_out, fwd_rd;
  logic [31:0] addr_in, rdata_in, addr_out, rdata_out, wdata_out, fwd_data;
`ifdef MEM_WB_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] rdata;
  } beat_t;

  always #5 clk = ~clk;

  mem_wb_skid_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wb_in     (wb_in),
    .rd_in     (rd_in),
    .addr_in   (addr_in),
    .rdata_in  (rdata_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_out    (wb_out),
    .rd_out    (rd_out),
    .addr_out  (addr_out),
    .rdata_out (rdata_out),
    .wdata_out (wdata_out),
    .fwd_en    (fwd_en),
    .fwd_rd    (fwd_rd),
`ifdef MEM_WB_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt),
`endif
    .fwd_data  (fwd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] rdata);
    in_valid = v;
    wb_in    = wb;
    rd_in    = rd;
    addr_in  = addr;
    rdata_in = rdata;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 5'd5, 32'h55, 32'h66);
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || wdata_out !== 32'd0 || fwd_en !== 1'b0 ||
        addr_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b wdata=%h fwd_en=%b addr=%h, want 0 1 0 0 0",
               out_valid, in_ready, wdata_out, fwd_en, addr_out);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || addr_out !== 32'h55) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b addr=%h, want 1 00000055", out_valid, addr_out);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 5'd3, 32'(16 * (i + 1)), 32'hFFFF_0000);
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || wdata_out !== 32'(16 * (i + 1)) || fwd_en !== 1'b1 ||
          fwd_rd !== 5'd3 || fwd_data !== 32'(16 * (i + 1))) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b wdata=%h fwd_en=%b fwd_rd=%0d, want 1 %h 1 3",
                 i, out_valid, wdata_out, fwd_en, fwd_rd, 32'(16 * (i + 1)));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || fwd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b fwd_en=%b, want 0 0", out_valid, fwd_en);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 5'd4, 32'h100, 32'h0);
    tick();
    drive(1'b1, 2'b10, 5'd4, 32'h200, 32'h0);
    tick();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || addr_out !== 32'h100) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b valid=%b addr=%h, want 0 1 00000100",
               in_ready, out_valid, addr_out);
    end
    drive(1'b1, 2'b10, 5'd4, 32'h300, 32'h0);
    tick();
    n_tests++;
    if (in_ready !== 1'b0 || addr_out !== 32'h100) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b addr=%h, want 0 00000100", in_ready, addr_out);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || addr_out !== 32'h200 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_b: valid=%b addr=%h ready=%b, want 1 00000200 1",
               out_valid, addr_out, in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || addr_out !== 32'h300) begin
      n_fail++;
      $display("FAIL bp_c: valid=%b addr=%h, want 1 00000300", out_valid, addr_out);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_mem_to_reg();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 5'd7, 32'hAAAA_0000, 32'h1234_5678);
    tick();
    n_tests++;
    if (wdata_out !== 32'h1234_5678 || fwd_data !== 32'h1234_5678 || fwd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL m2r_load: wdata=%h fwd_data=%h fwd_en=%b, want 12345678 12345678 1",
               wdata_out, fwd_data, fwd_en);
    end
    drive(1'b1, 2'b10, 5'd7, 32'hAAAA_0000, 32'h1234_5678);
    tick();
    n_tests++;
    if (wdata_out !== 32'hAAAA_0000) begin
      n_fail++;
      $display("FAIL m2r_alu: wdata=%h, want aaaa0000", wdata_out);
    end
    drive(1'b1, 2'b00, 5'd7, 32'hAAAA_0000, 32'h1234_5678);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || fwd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL m2r_noregwr: valid=%b fwd_en=%b, want 1 0", out_valid, fwd_en);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 5'd9, 32'h111, 32'h0);
    tick();
    drive(1'b1, 2'b10, 5'd9, 32'h222, 32'h0);
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 5'd9, 32'hDEAD, 32'h0);
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fwd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: valid=%b ready=%b fwd_en=%b, want 0 1 0",
               out_valid, in_ready, fwd_en);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: valid=%b addr=%h, want valid 0", out_valid, addr_out);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 5'd0, 32'h44, 32'h0);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || fwd_en !== 1'b0 || fwd_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL rd_zero: valid=%b fwd_en=%b fwd_rd=%0d, want 1 0 0",
               out_valid, fwd_en, fwd_rd);
    end
    in_valid = 1'b0;
  endtask

`ifdef MEM_WB_PERF_EN
  task automatic test_perf();
    do_reset();
    n_tests++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_reset: stall=%0d bubble=%0d flush=%0d, want 0 0 0",
               stall_cnt, bubble_cnt, flush_cnt);
    end
    drive(1'b1, 2'b10, 5'd2, 32'h1, 32'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_stall: stall=%0d bubble=%0d, want 5 1", stall_cnt, bubble_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL perf_flush: flush=%0d stall=%0d, want 1 6", flush_cnt, stall_cnt);
    end
  endtask
`endif

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    logic  acc, pp, exp_fwd;
    logic [31:0] exp_wdata;
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_fwd = 1'b0;
      if (q.size() > 0) exp_fwd = q[0].wb[1] && (q[0].rd != 5'd0);
      n_tests++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || fwd_en !== exp_fwd) begin
        n_fail++;
        $display("FAIL rand_ctrl@%0d: valid=%b ready=%b fwd_en=%b, want %b %b %b", cyc,
                 out_valid, in_ready, fwd_en, q.size() > 0, q.size() < 2, exp_fwd);
      end
      if (q.size() > 0) begin
        exp_wdata = q[0].wb[0] ? q[0].rdata : q[0].addr;
        n_tests++;
        if (wb_out !== q[0].wb || rd_out !== q[0].rd || addr_out !== q[0].addr ||
            rdata_out !== q[0].rdata || wdata_out !== exp_wdata || fwd_data !== exp_wdata ||
            fwd_rd !== q[0].rd) begin
          n_fail++;
          $display("FAIL rand_data@%0d: wb=%b rd=%0d addr=%h rdata=%h wdata=%h, want %b %0d %h %h %h",
                   cyc, wb_out, rd_out, addr_out, rdata_out, wdata_out,
                   q[0].wb, q[0].rd, q[0].addr, q[0].rdata, exp_wdata);
        end
      end
      b.wb    = 2'($urandom);
      b.rd    = 5'($urandom);
      b.addr  = $urandom;
      b.rdata = $urandom;
      drive(($urandom % 4) != 0, b.wb, b.rd, b.addr, b.rdata);
      out_ready = ($urandom % 10) < 6;
      flush     = ($urandom % 25) == 0;
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mem_to_reg();
    test_flush();
    test_rd_zero();
`ifdef MEM_WB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
